// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped data memory: I/O region offsets and STATUS layout.
package mmio_pkg;

  localparam int MAX_CH = 16;

  // Byte offsets inside the 4 KiB I/O region
  localparam logic [11:0] OFS_IN     = 12'h000;
  localparam logic [11:0] OFS_OUT    = 12'h040;
  localparam logic [11:0] OFS_STATUS = 12'h080;

  // STATUS word layout. Only 15 out_valid bits fit below ovf, so with 16
  // channels out_valid[15] is not visible in STATUS; bit 31 is always ovf.
  localparam int ST_IN_FULL_LSB   = 0;
  localparam int ST_OUT_VALID_LSB = 16;
  localparam int ST_OUT_VALID_MAX = 15;
  localparam int ST_OVF_BIT       = 31;

endpackage

// File: rtl/mmio_channel.sv
// One I/O channel: one-entry input buffer and one-entry output buffer with valid/ready handshakes.
// Handshake: a word transfers at a rising edge where valid and ready are both 1.
module mmio_channel #(
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_in_buf,
  output logic              o_in_full,
  input  logic              i_out_wr,
  input  logic [DATA_W-1:0] i_out_word,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              o_drop
);

  logic              r_in_full;
  logic [DATA_W-1:0] r_in_buf;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_buf;
  logic              w_capture;
  logic              w_out_blocked;

  // Pop requires full and capture requires empty, so they never coincide
  assign w_capture     = in_valid && !r_in_full;
  assign w_out_blocked = r_out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_full   <= 1'b0;
      r_in_buf    <= '0;
      r_out_valid <= 1'b0;
      r_out_buf   <= '0;
    end else begin
      if (w_capture) begin
        r_in_buf  <= in_data;
        r_in_full <= 1'b1;
      end else if (i_pop && r_in_full) begin
        r_in_full <= 1'b0;
      end

      if (i_out_wr) begin
        if (!w_out_blocked) begin
          r_out_buf   <= i_out_word;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !r_in_full;
  assign o_in_full = r_in_full;
  assign o_in_buf  = r_in_buf;
  assign out_data  = r_out_buf;
  assign out_valid = r_out_valid;
  assign o_drop    = i_out_wr && w_out_blocked;

endmodule

// File: rtl/mmio_data_mem.sv
// Word-addressed data RAM plus a memory-mapped fixed-point channel region for the core's load/store port.
module mmio_data_mem
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 256,
  parameter int          NUM_CH  = 2,
  parameter int          DATA_W  = 31,
  parameter logic [31:0] IO_BASE = 32'h0000_4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              addr,
  input  logic [31:0]              wr_data,
  input  logic                     lw_en,
  input  logic                     sw_en,
  output logic [31:0]              rd_data,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic              r_ovf;

  logic              w_ram_hit;
  logic              w_io_hit;
  logic              w_in_hit;
  logic              w_out_hit;
  logic              w_status_hit;
  logic [NUM_CH-1:0] w_in_sel;
  logic [NUM_CH-1:0] w_out_sel;
  logic [NUM_CH-1:0] w_in_full;
  logic [NUM_CH-1:0] w_drop;
  logic [DATA_W-1:0] w_in_buf [NUM_CH];
  logic [31:0]       w_status;
  logic              w_unused;

  assign w_ram_hit    = (addr[31:AW+2] == '0);
  assign w_io_hit     = (addr[31:12] == IO_BASE[31:12]);
  assign w_in_hit     = w_io_hit && (addr[11:6] == OFS_IN[11:6]);
  assign w_out_hit    = w_io_hit && (addr[11:6] == OFS_OUT[11:6]);
  assign w_status_hit = w_io_hit && (addr[11:2] == OFS_STATUS[11:2]);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_in_sel[g]  = w_in_hit  && (addr[5:2] == 4'(g));
      assign w_out_sel[g] = w_out_hit && (addr[5:2] == 4'(g));

      mmio_channel #(.DATA_W(DATA_W)) u_ch (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data[g*DATA_W +: DATA_W]),
        .in_valid   (in_valid[g]),
        .in_ready   (in_ready[g]),
        .i_pop      (lw_en && w_in_sel[g]),
        .o_in_buf   (w_in_buf[g]),
        .o_in_full  (w_in_full[g]),
        .i_out_wr   (sw_en && w_out_sel[g]),
        .i_out_word (wr_data[DATA_W-1:0]),
        .out_data   (out_data[g*DATA_W +: DATA_W]),
        .out_valid  (out_valid[g]),
        .out_ready  (out_ready[g]),
        .o_drop     (w_drop[g])
      );
    end
  endgenerate

  // RAM is never reset so it maps onto memory primitives
  always_ff @(posedge clk) begin
    if (sw_en && w_ram_hit) begin
      r_mem[addr[AW+1:2]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end else if (sw_en && w_status_hit && wr_data[ST_OVF_BIT]) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_status[ST_IN_FULL_LSB + c] = w_in_full[c];
      if (c < ST_OUT_VALID_MAX) begin
        w_status[ST_OUT_VALID_LSB + c] = out_valid[c];
      end
    end
    w_status[ST_OVF_BIT] = r_ovf;
  end

  always_comb begin
    rd_data = '0;
    if (w_ram_hit) begin
      rd_data = r_mem[addr[AW+1:2]];
    end else if (w_status_hit) begin
      rd_data = w_status;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_in_sel[c]) begin
          rd_data = 32'(w_in_buf[c]);
        end
        if (w_out_sel[c]) begin
          rd_data = 32'(out_data[c*DATA_W +: DATA_W]);
        end
      end
    end
  end

  assign w_unused = ^{addr[1:0], wr_data};

endmodule

// File: tb/tb_mmio_data_mem.sv
// Directed bench for mmio_data_mem: a vector table for address decode plus handshake sequences.
module tb_mmio_data_mem;

  localparam int          NUM_CH  = 2;
  localparam int          DATA_W  = 31;
  localparam logic [31:0] IO_BASE = 32'h0000_4000;
  localparam logic [31:0] A_IN0   = IO_BASE + 32'h00;
  localparam logic [31:0] A_IN1   = IO_BASE + 32'h04;
  localparam logic [31:0] A_OUT0  = IO_BASE + 32'h40;
  localparam logic [31:0] A_OUT1  = IO_BASE + 32'h44;
  localparam logic [31:0] A_STAT  = IO_BASE + 32'h80;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [31:0]              addr = '0;
  logic [31:0]              wr_data = '0;
  logic                     lw_en = 1'b0;
  logic                     sw_en = 1'b0;
  logic [31:0]              rd_data;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready = '0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        do_store;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  mmio_data_mem #(.DEPTH(256), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IO_BASE(IO_BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_data   (wr_data),
    .lw_en     (lw_en),
    .sw_en     (sw_en),
    .rd_data   (rd_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_data = d; sw_en = 1'b1;
    tick();
    sw_en = 1'b0;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    // Reset with producers already asserting valid
    rst = 1'b1; in_valid = 2'b11;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'h3);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data[31:0], 32'h0);
    in_valid = 2'b00; rst = 1'b0;
    peek("rst_status", A_STAT, 32'h0);

    vecs.push_back('{32'h0000_03FC, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h1234_5678});
    vecs.push_back('{32'h0000_03FD, 32'h0,         1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_8000, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{32'h0000_8000, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{IO_BASE + 32'h84, 32'h0,      1'b0, 32'h0});
    vecs.push_back('{IO_BASE + 32'h08, 32'h0,      1'b0, 32'h0});
    vecs.push_back('{A_IN1,            32'h5555_5555, 1'b1, 32'h0});
    vecs.push_back('{A_OUT1,           32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_store) store(vecs[i].addr, vecs[i].wdata);
      peek($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
    end
    chk("vec_out1_valid", 32'(out_valid), 32'h2);
    out_ready = 2'b10;
    tick();
    out_ready = 2'b00;
    chk("out1_drain", 32'(out_valid), 32'h0);

    // Input channel 1 capture and pop
    in_data = {31'h4000_0000, 31'h0};
    in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    chk("in1_ready_low", 32'(in_ready), 32'h1);
    peek("in1_status", A_STAT, 32'h0000_0002);
    addr = A_IN1; lw_en = 1'b1;
    #1;
    chk("in1_load", rd_data, 32'h4000_0000);
    tick();
    lw_en = 1'b0;
    chk("in1_ready_back", 32'(in_ready), 32'h3);
    addr = A_IN1; lw_en = 1'b1;
    #1;
    chk("in1_stale", rd_data, 32'h4000_0000);
    tick();
    lw_en = 1'b0;
    peek("in1_stale_status", A_STAT, 32'h0);

    // Output backpressure and overflow
    out_ready = 2'b00;
    store(A_OUT0, 32'h1);
    store(A_OUT0, 32'h2);
    chk("bp_out_data", out_data[31:0] & 32'h7FFF_FFFF, 32'h1);
    peek("bp_status", A_STAT, 32'h8001_0000);
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    chk("bp_drain", 32'(out_valid), 32'h0);
    peek("bp_ovf_sticky", A_STAT, 32'h8000_0000);
    store(A_STAT, 32'h8000_0000);
    peek("ovf_clear", A_STAT, 32'h0);

    // Store and drain in the same cycle
    store(A_OUT0, 32'h5);
    chk("sd_valid_pre", 32'(out_valid), 32'h1);
    out_ready = 2'b01;
    store(A_OUT0, 32'h3);
    chk("sd_valid", 32'(out_valid), 32'h1);
    chk("sd_data", out_data[31:0] & 32'h7FFF_FFFF, 32'h3);
    peek("sd_no_ovf", A_STAT, 32'h0001_0000);
    tick();
    out_ready = 2'b00;
    chk("sd_final_drain", 32'(out_valid), 32'h0);

    // Reset in the middle of pending transfers
    in_data = {31'h0, 31'h0000_0123};
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    store(A_OUT0, 32'h7);
    chk("mr_pre_ready", 32'(in_ready), 32'h2);
    chk("mr_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready", 32'(in_ready), 32'h3);
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    peek("mr_status", A_STAT, 32'h0);
    tick();
    chk("mr_no_spurious", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
